pipe_haz_ctrl: RTL and testbench

PIPE_HAZ_CTRL -- requirements
Module: pipe_haz_ctrl

---
 rtl/pipe_haz_ctrl_pkg.sv | 16 +
 rtl/pipe_haz_ctrl_haz_detect.sv | 22 ++
 rtl/pipe_haz_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_haz_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_haz_ctrl_pkg.sv
// Shared pipeline definitions: FSM state encodings and hazard-control defaults
// used by every pipe_* block.
package pipe_haz_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_LDUSE   = 3'd1,
        ST_MEMWAIT = 3'd2,
        ST_HALT    = 3'd4
    } pipe_state_e;

    localparam int unsigned LU_CYCLES_DEF = 2;
    localparam int unsigned LU_CNT_W      = 3;
    localparam int unsigned REG_W         = 3;

endpackage

// File: rtl/pipe_haz_ctrl_haz_detect.sv
// Load-use detector: the instruction in IF/ID reads a register that the load
// currently in ID/EX has not yet produced. r0 is deliberately not exempted.
module haz_detect
    import pipe_haz_ctrl_pkg::*;
(
    input  logic             idex_mem_read_i,
    input  logic [REG_W-1:0] idex_rd_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             ifid_rs_used_i,
    input  logic             ifid_rt_used_i,
    output logic             load_use_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit     = ifid_rs_used_i && (ifid_rs_i == idex_rd_i);
    assign rt_hit     = ifid_rt_used_i && (ifid_rt_i == idex_rd_i);
    assign load_use_o = idex_mem_read_i && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_haz_ctrl.sv
// Pipeline hazard controller: load-use stalls, memory-wait freeze, EX redirect
// flush and terminal halt, with a saturating stalled-cycle counter.
module pipe_haz_ctrl
    import pipe_haz_ctrl_pkg::*;
#(
    parameter int unsigned LU_CYCLES = LU_CYCLES_DEF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_mem_read,
    input  logic [2:0]       idex_rd,
    input  logic [2:0]       ifid_rs,
    input  logic [2:0]       ifid_rt,
    input  logic             ifid_rs_used,
    input  logic             ifid_rt_used,
    input  logic             ex_redirect,
    input  logic             mem_stall,
    input  logic             excp,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_e         state_q, state_d;
    logic [LU_CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                load_use;
    logic                in_halt;

    haz_detect u_haz_detect (
        .idex_mem_read_i (idex_mem_read),
        .idex_rd_i       (idex_rd),
        .ifid_rs_i       (ifid_rs),
        .ifid_rt_i       (ifid_rt),
        .ifid_rs_used_i  (ifid_rs_used),
        .ifid_rt_used_i  (ifid_rt_used),
        .load_use_o      (load_use)
    );

    assign in_halt = !(state_q inside {ST_RUN, ST_LDUSE, ST_MEMWAIT});

    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        idex_we    = 1'b1;
        exmem_we   = 1'b1;
        memwb_we   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        state_d    = state_q;
        lu_cnt_d   = lu_cnt_q;

        case (state_q)
            ST_RUN, ST_LDUSE: begin
                if (excp) begin
                    {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
                    state_d = ST_HALT;
                end else if (mem_stall) begin
                    {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
                    state_d = ST_MEMWAIT;
                end else if (ex_redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    lu_cnt_d   = '0;
                    state_d    = ST_RUN;
                end else if (state_q == ST_LDUSE && lu_cnt_q != '0) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                    lu_cnt_d   = lu_cnt_q - 1'b1;
                    state_d    = (lu_cnt_q == 1) ? ST_RUN : ST_LDUSE;
                end else if (load_use) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                    lu_cnt_d   = LU_CNT_W'(LU_CYCLES - 1);
                    state_d    = (LU_CYCLES > 1) ? ST_LDUSE : ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            // Exceptions raised while memory is busy wait for the access to finish.
            ST_MEMWAIT: begin
                if (mem_stall) begin
                    {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
                end else if (excp) begin
                    {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
                    state_d = ST_HALT;
                end else begin
                    state_d = (lu_cnt_q != '0) ? ST_LDUSE : ST_RUN;
                end
            end
            default: begin
                {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
                state_d = ST_HALT;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_we && !in_halt && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            lu_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lu_cnt_q    <= lu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_haz_ctrl.sv
// Directed-vector bench for pipe_haz_ctrl: the driver queues hand-computed
// expectations, a negedge monitor checks two instances (CNT_W=16 and CNT_W=2).
module tb_pipe_haz_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       idex_mem_read = 1'b0;
    logic [2:0] idex_rd = '0, ifid_rs = '0, ifid_rt = '0;
    logic       ifid_rs_used = 1'b0, ifid_rt_used = 1'b0;
    logic       ex_redirect = 1'b0, mem_stall = 1'b0, excp = 1'b0;

    logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush;
    logic [2:0]  state;
    logic [15:0] stall_cnt;
    logic        pc_we2, ifid_we2, idex_we2, exmem_we2, memwb_we2, ifid_flush2, idex_flush2;
    logic [2:0]  state2;
    logic [1:0]  stall_cnt2;

    always #5 clk = ~clk;

    pipe_haz_ctrl #(.LU_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_rs_used(ifid_rs_used),
        .ifid_rt_used(ifid_rt_used), .ex_redirect(ex_redirect), .mem_stall(mem_stall),
        .excp(excp), .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
        .exmem_we(exmem_we), .memwb_we(memwb_we), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .state(state), .stall_cnt(stall_cnt)
    );

    pipe_haz_ctrl #(.LU_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_rs_used(ifid_rs_used),
        .ifid_rt_used(ifid_rt_used), .ex_redirect(ex_redirect), .mem_stall(mem_stall),
        .excp(excp), .pc_we(pc_we2), .ifid_we(ifid_we2), .idex_we(idex_we2),
        .exmem_we(exmem_we2), .memwb_we(memwb_we2), .ifid_flush(ifid_flush2),
        .idex_flush(idex_flush2), .state(state2), .stall_cnt(stall_cnt2)
    );

    typedef struct packed {
        logic [4:0]  we;
        logic        ifl;
        logic        idfl;
        logic [2:0]  st;
        logic [15:0] cnt;
        int          vec;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_vec  = 0;

    // Drive one cycle's inputs just after the edge and queue what that cycle must show.
    task automatic step(input logic r, input logic mr, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [2:0] rt,
                        input logic rsu, input logic rtu, input logic rdr,
                        input logic ms, input logic ex,
                        input logic [4:0] we, input logic ifl, input logic idfl,
                        input logic [2:0] st, input int cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; idex_mem_read = mr; idex_rd = rd; ifid_rs = rs; ifid_rt = rt;
        ifid_rs_used = rsu; ifid_rt_used = rtu; ex_redirect = rdr;
        mem_stall = ms; excp = ex;
        n_vec++;
        e.we = we; e.ifl = ifl; e.idfl = idfl; e.st = st; e.cnt = 16'(cnt); e.vec = n_vec;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [9:0]  exp_ctl, act_ctl, act_ctl2;
        logic [1:0]  exp_c2;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                exp_ctl  = {e.we, e.ifl, e.idfl, e.st};
                act_ctl  = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush, state};
                act_ctl2 = {pc_we2, ifid_we2, idex_we2, exmem_we2, memwb_we2, ifid_flush2, idex_flush2, state2};
                exp_c2   = (e.cnt > 16'd3) ? 2'd3 : e.cnt[1:0];
                n_chk++;
                if (act_ctl !== exp_ctl) begin
                    n_fail++;
                    $display("FAIL ctl vec%0d: got we=%b fl=%b%b st=%0d, want we=%b fl=%b%b st=%0d",
                             e.vec, act_ctl[9:5], act_ctl[4], act_ctl[3], act_ctl[2:0],
                             e.we, e.ifl, e.idfl, e.st);
                end
                n_chk++;
                if (stall_cnt !== e.cnt) begin
                    n_fail++;
                    $display("FAIL stall_cnt vec%0d: got %0d, want %0d", e.vec, stall_cnt, e.cnt);
                end
                n_chk++;
                if ({act_ctl2, stall_cnt2} !== {exp_ctl, exp_c2}) begin
                    n_fail++;
                    $display("FAIL sat_dut vec%0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                             e.vec, act_ctl2, stall_cnt2, exp_ctl, exp_c2);
                end
            end
        end
    end

    initial begin : driver
        // reset, then release
        step(0, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,0);
        step(0, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,0);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,0);
        // load r3, consumer reads rs=3: two stall cycles
        step(1, 1,3,3,2,1,0,0,0,0, 5'b00111,0,1,0,0);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b00111,0,1,1,1);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,2);
        // rt matches but unused: no stall; r0 match does stall
        step(1, 1,3,1,3,1,0,0,0,0, 5'b11111,0,0,0,2);
        step(1, 1,0,0,2,1,0,0,0,0, 5'b00111,0,1,0,2);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b00111,0,1,1,3);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,4);
        // rt-path load-use, redirect in second stall cycle aborts stall
        step(1, 1,5,1,5,0,1,0,0,0, 5'b00111,0,1,0,4);
        step(1, 0,0,1,2,0,0,1,0,0, 5'b11111,1,1,1,5);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,5);
        step(1, 0,0,1,2,0,0,1,0,0, 5'b11111,1,1,0,5);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,5);
        // mem_stall for 3 cycles in RUN
        step(1, 0,0,1,2,0,0,0,1,0, 5'b00000,0,0,0,5);
        step(1, 0,0,1,2,0,0,0,1,0, 5'b00000,0,0,2,6);
        step(1, 0,0,1,2,0,0,0,1,0, 5'b00000,0,0,2,7);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,2,8);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,8);
        // mem_stall during LDUSE keeps the remaining stall
        step(1, 1,3,3,2,1,0,0,0,0, 5'b00111,0,1,0,8);
        step(1, 0,0,1,2,0,0,0,1,0, 5'b00000,0,0,1,9);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,2,10);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b00111,0,1,1,10);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,11);
        // async reset in the middle of LDUSE
        step(1, 1,3,3,2,1,0,0,0,0, 5'b00111,0,1,0,11);
        step(0, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,0);
        step(0, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,0);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,0);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,0);
        // excp while mem_stall: held in MEMWAIT, HALT once memory is done
        step(1, 0,0,1,2,0,0,0,1,0, 5'b00000,0,0,0,0);
        step(1, 0,0,1,2,0,0,0,1,1, 5'b00000,0,0,2,1);
        step(1, 0,0,1,2,0,0,0,1,1, 5'b00000,0,0,2,2);
        step(1, 0,0,1,2,0,0,0,0,1, 5'b00000,0,0,2,3);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b00000,0,0,4,4);
        step(1, 0,0,1,2,0,0,1,0,0, 5'b00000,0,0,4,4);
        step(1, 1,3,3,2,1,0,0,0,0, 5'b00000,0,0,4,4);
        // excp wins over mem_stall and redirect in RUN
        step(0, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,0);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,0);
        step(1, 0,0,1,2,0,0,1,1,1, 5'b00000,0,0,0,0);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b00000,0,0,4,1);
        // redirect beats load-use; excp inside LDUSE
        step(0, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,0);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,0);
        step(1, 1,3,3,2,1,0,1,0,0, 5'b11111,1,1,0,0);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b11111,0,0,0,0);
        step(1, 1,3,3,2,1,0,0,0,0, 5'b00111,0,1,0,0);
        step(1, 0,0,1,2,0,0,0,0,1, 5'b00000,0,0,1,1);
        step(1, 0,0,1,2,0,0,0,0,0, 5'b00000,0,0,4,2);
        repeat (3) @(posedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
